udma_filter_tx_datain: RTL and testbench
========================================

UDMA_FILTER_TX_DATAIN -- requirements
Module: udma_filter_tx_datain

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- DATA_WIDTH, 32, stream and channel data width.
- L2_AWIDTH_NOAL, 15, L2 address width.
- BUFFER_DEPTH, 4, FIFO entries, power of 2, at least 2.
- TRANS_SIZE, 16, length field width.
REQ-002 Clock and reset SHALL be:
- clk_i  in  1  single clock.
- resetn_i  in  1  reset, asynchronous and active-low.
REQ-003 TX channel ports SHALL be:
- tx_ch_req_o  out  1  read request.
- tx_ch_addr_o  out  L2_AWIDTH_NOAL  read address.
- tx_ch_datasize_o  out  2  access size.
- tx_ch_gnt_i  in  1  request accepted.
- tx_ch_valid_i  in  1  read data valid.
- tx_ch_data_i  in  DATA_WIDTH  read data.
- tx_ch_ready_o  out  1  tied high.
REQ-004 Command ports SHALL be:
- cmd_start_i  in  1  start pulse.
- cmd_done_o  out  1  one-cycle done pulse.
REQ-005 Configuration ports SHALL be:
- cfg_start_addr_i  in  L2_AWIDTH_NOAL  start address.
- cfg_datasize_i  in  2  element size.
- cfg_mode_i  in  2  addressing mode.
- cfg_len0_i, cfg_len1_i, cfg_len2_i  in  TRANS_SIZE  each  lengths and stride.
REQ-006 Stream ports SHALL be:
- stream_data_o  out  DATA_WIDTH  output data.
- stream_datasize_o  out  2  element size.
- stream_valid_o  out  1  data valid.
- stream_sof_o  out  1  first element flag.
- stream_eof_o  out  1  last element flag.
- stream_ready_i  in  1  downstream ready.

Function
REQ-007 The FSM SHALL have states IDLE, RUN and DRAIN. IDLE goes to RUN on cmd_start_i. RUN goes to DRAIN when the last request is granted. DRAIN goes to IDLE when the eof element is accepted.
REQ-008 In the start cycle, mode, start address, datasize and len0/1/2 SHALL be latched, and counters w and l SHALL be cleared. cmd_start_i outside IDLE SHALL be ignored.
REQ-009 The datasize increment SHALL be 00→1, 01→2, 10→4, 11→0.
REQ-010 Address sequencing SHALL advance only on tx_ch_req_o && tx_ch_gnt_i:
- Mode 0 (linear): len0+1 elements at consecutive increments.
- Mode 1 (2D row): inner w runs 0..len0 with address += increment; at w==len0, row base += len2 and l++; total (len0+1)*(len1+1) elements.
- Mode 2 (2D col): inner l runs 0..len1 with address += len2; at l==len1, column base += increment and w++; same total as mode 1.
- Mode 3 SHALL behave as mode 0.
REQ-011 Address arithmetic SHALL wrap modulo 2^L2_AWIDTH_NOAL.
REQ-012 tx_ch_req_o SHALL be asserted only in RUN and only when outstanding + FIFO occupancy < BUFFER_DEPTH.
REQ-013 tx_ch_addr_o and tx_ch_datasize_o SHALL hold stable while tx_ch_req_o is high and tx_ch_gnt_i is low.
REQ-014 Outstanding accounting SHALL be:
- Increment on grant, decrement on tx_ch_valid_i; a simultaneous grant and valid leaves the count unchanged.
- Counter width is $clog2(BUFFER_DEPTH)+1.
REQ-015 tx_ch_valid_i with zero outstanding SHALL be discarded.
REQ-016 Every tx_ch_valid_i beat with outstanding > 0 SHALL be written into the FIFO in the same cycle; overflow is impossible by REQ-012.
REQ-017 Stream flags SHALL be:
- stream_sof_o high on the first element of a command only.
- stream_eof_o high on the last element only.
- Both high for a single-element transfer.
- stream_datasize_o equals the latched datasize.
REQ-018 Stream data, valid, sof and eof SHALL hold stable while stream_valid_o && !stream_ready_i.
REQ-019 cmd_done_o SHALL pulse in the cycle the eof element is accepted, and the FSM SHALL be in IDLE on the next cycle.
REQ-020 A new cmd_start_i SHALL be accepted in that next cycle.
REQ-021 The first request SHALL appear at the earliest one cycle after cmd_start_i.

Reset
REQ-022 Asserting resetn_i low SHALL force, asynchronously:
- State to IDLE.
- All counters, addresses and latched configuration to 0.
- FIFO to empty.
- tx_ch_req_o, cmd_done_o, stream_valid_o, stream_sof_o and stream_eof_o to 0.
REQ-023 Reset mid-transfer SHALL abandon the transfer with no done pulse.

Structure
REQ-024 Mode constants (LINEAR=0, 2D_ROW=1, 2D_COL=2) and the state enum SHALL reside in package udma_filter_pkg.
REQ-025 Buffering SHALL use the single sub-module io_generic_fifo, with DATA_WIDTH+2 bits to carry sof and eof, and its elements output feeding the credit check.

Verification
REQ-026 Linear test: start_addr=0x100, datasize=10, len0=3, stream_ready=1, immediate gnt, one-cycle read latency → addresses 0x100, 0x104, 0x108, 0x10C; 4 stream beats; sof on beat 0; eof and done on beat 3.
REQ-027 2D row test: start_addr=0, datasize=00, len0=1, len1=2, len2=0x10 → addresses 0x0, 0x1, 0x10, 0x11, 0x20, 0x21.
REQ-028 2D col test: same configuration in mode 2 → addresses 0x0, 0x10, 0x20, 0x1, 0x11, 0x21.
REQ-029 Backpressure test: stream_ready=0 for 20 cycles, BUFFER_DEPTH=4 → at most 4 grants, then req stays low; data is held stable; all beats delivered after release with no loss.
REQ-030 Mid-transfer test: cmd_start during RUN is ignored; resetn low on element 2 of 8 → all outputs 0 and no done pulse; a new command after reset completes normally.
REQ-031 Edge test: len0=0 linear gives exactly one beat with sof=eof=1 and done; start_addr=0x7FFC, datasize=10, len0=1 gives addresses 0x7FFC, 0x0000.

Source files
------------

// File: rtl/udma_filter_pkg.sv
// Shared constants and types for the uDMA TX data-in filter channel.
package udma_filter_pkg;

  localparam logic [1:0] MODE_LINEAR = 2'd0;
  localparam logic [1:0] MODE_2D_ROW = 2'd1;
  localparam logic [1:0] MODE_2D_COL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Byte increment per element; size code 3 is a zero-stride access.
  function automatic logic [2:0] datasize_incr(input logic [1:0] ds);
    case (ds)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/io_generic_fifo.sv
// Synchronous FIFO with occupancy output; head word is presented directly from storage.
module io_generic_fifo #(
  parameter int unsigned DATA_WIDTH   = 34,
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  output logic [$clog2(BUFFER_DEPTH):0]   elements_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  input  logic                            valid_i,
  input  logic [DATA_WIDTH-1:0]           data_i
);

  localparam int unsigned PW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_push     = valid_i && (r_count != CW'(BUFFER_DEPTH));
  assign w_pop      = valid_o && ready_i;
  assign valid_o    = (r_count != '0);
  assign data_o     = r_mem[r_rptr];
  assign elements_o = r_count;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < BUFFER_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/udma_filter_tx_datain.sv
// Reads linear / 2D-row / 2D-column element sequences from L2 and streams them out with sof/eof tags.
module udma_filter_tx_datain
  import udma_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned L2_AWIDTH_NOAL = 15,
  parameter int unsigned BUFFER_DEPTH   = 4,
  parameter int unsigned TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  output logic                      tx_ch_req_o,
  output logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr_o,
  output logic [1:0]                tx_ch_datasize_o,
  input  logic                      tx_ch_gnt_i,
  input  logic                      tx_ch_valid_i,
  input  logic [DATA_WIDTH-1:0]     tx_ch_data_i,
  output logic                      tx_ch_ready_o,
  input  logic                      cmd_start_i,
  output logic                      cmd_done_o,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
  output logic [DATA_WIDTH-1:0]     stream_data_o,
  output logic [1:0]                stream_datasize_o,
  output logic                      stream_valid_o,
  output logic                      stream_sof_o,
  output logic                      stream_eof_o,
  input  logic                      stream_ready_i
);

  localparam int unsigned CW = $clog2(BUFFER_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned FW = DATA_WIDTH + 2;
  localparam int unsigned AW = L2_AWIDTH_NOAL;
  localparam int unsigned TW = TRANS_SIZE;

  state_e          r_state, w_state_nxt;
  logic [1:0]      r_mode, r_datasize;
  logic [AW-1:0]   r_addr, r_base, w_addr_nxt, w_base_nxt, w_incr, w_stride;
  logic [TW-1:0]   r_len0, r_len1, r_len2, r_w, r_l, w_w_nxt, w_l_nxt;
  logic [CW-1:0]   r_outstanding, w_elements;
  logic            r_sof_pend;
  logic            w_start, w_req, w_grant, w_last_req, w_valid_acc, w_eof_acc, w_beat_eof;
  logic [FW-1:0]   w_fifo_wdata, w_fifo_rdata;
  logic            w_fifo_valid;

  assign w_start     = (r_state == ST_IDLE) && cmd_start_i;
  assign w_req       = (r_state == ST_RUN) &&
                       ((SW'(r_outstanding) + SW'(w_elements)) < SW'(BUFFER_DEPTH));
  assign w_grant     = w_req && tx_ch_gnt_i;
  assign w_valid_acc = tx_ch_valid_i && (r_outstanding != '0);
  assign w_incr      = AW'(datasize_incr(r_datasize));
  assign w_stride    = AW'(r_len2);
  assign w_eof_acc   = w_fifo_valid && stream_ready_i && w_fifo_rdata[FW-1];

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_start_i)            w_state_nxt = ST_RUN;
      ST_RUN:   if (w_grant && w_last_req)  w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_eof_acc)              w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  // Next address / counter values, applied only when a request is granted.
  always_comb begin
    w_addr_nxt = r_addr;
    w_base_nxt = r_base;
    w_w_nxt    = r_w;
    w_l_nxt    = r_l;
    w_last_req = 1'b0;
    case (r_mode)
      MODE_2D_ROW: begin
        w_last_req = (r_w == r_len0) && (r_l == r_len1);
        if (r_w == r_len0) begin
          w_w_nxt    = '0;
          w_l_nxt    = r_l + TW'(1);
          w_base_nxt = r_base + w_stride;
          w_addr_nxt = r_base + w_stride;
        end else begin
          w_w_nxt    = r_w + TW'(1);
          w_addr_nxt = r_addr + w_incr;
        end
      end
      MODE_2D_COL: begin
        w_last_req = (r_w == r_len0) && (r_l == r_len1);
        if (r_l == r_len1) begin
          w_l_nxt    = '0;
          w_w_nxt    = r_w + TW'(1);
          w_base_nxt = r_base + w_incr;
          w_addr_nxt = r_base + w_incr;
        end else begin
          w_l_nxt    = r_l + TW'(1);
          w_addr_nxt = r_addr + w_stride;
        end
      end
      default: begin
        w_last_req = (r_w == r_len0);
        w_w_nxt    = r_w + TW'(1);
        w_addr_nxt = r_addr + w_incr;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_mode     <= '0;
      r_datasize <= '0;
      r_len0     <= '0;
      r_len1     <= '0;
      r_len2     <= '0;
      r_addr     <= '0;
      r_base     <= '0;
      r_w        <= '0;
      r_l        <= '0;
    end else if (w_start) begin
      r_mode     <= cfg_mode_i;
      r_datasize <= cfg_datasize_i;
      r_len0     <= cfg_len0_i;
      r_len1     <= cfg_len1_i;
      r_len2     <= cfg_len2_i;
      r_addr     <= cfg_start_addr_i;
      r_base     <= cfg_start_addr_i;
      r_w        <= '0;
      r_l        <= '0;
    end else if (w_grant) begin
      r_addr <= w_addr_nxt;
      r_base <= w_base_nxt;
      r_w    <= w_w_nxt;
      r_l    <= w_l_nxt;
    end
  end

  // In-flight reads; a grant and a return in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_outstanding <= '0;
      r_sof_pend    <= 1'b0;
    end else begin
      if (w_grant && !w_valid_acc)      r_outstanding <= r_outstanding + CW'(1);
      else if (!w_grant && w_valid_acc) r_outstanding <= r_outstanding - CW'(1);
      if (w_start)          r_sof_pend <= 1'b1;
      else if (w_valid_acc) r_sof_pend <= 1'b0;
    end
  end

  // The final beat is the one returning while draining with a single read left in flight.
  assign w_beat_eof   = (r_state == ST_DRAIN) && (r_outstanding == CW'(1));
  assign w_fifo_wdata = {w_beat_eof, r_sof_pend, tx_ch_data_i};

  io_generic_fifo #(
    .DATA_WIDTH   (FW),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (resetn_i),
    .elements_o (w_elements),
    .data_o     (w_fifo_rdata),
    .valid_o    (w_fifo_valid),
    .ready_i    (stream_ready_i),
    .valid_i    (w_valid_acc),
    .data_i     (w_fifo_wdata)
  );

  assign tx_ch_req_o       = w_req;
  assign tx_ch_addr_o      = r_addr;
  assign tx_ch_datasize_o  = r_datasize;
  assign tx_ch_ready_o     = 1'b1;
  assign cmd_done_o        = w_eof_acc;
  assign stream_data_o     = w_fifo_rdata[DATA_WIDTH-1:0];
  assign stream_datasize_o = r_datasize;
  assign stream_valid_o    = w_fifo_valid;
  assign stream_sof_o      = w_fifo_valid && w_fifo_rdata[DATA_WIDTH];
  assign stream_eof_o      = w_fifo_valid && w_fifo_rdata[FW-1];

endmodule

// File: tb/tb_udma_filter_tx_datain.sv
// Scoreboard bench: expected address and beat queues filled at command issue, drained by a monitor.
module tb_udma_filter_tx_datain;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 15;
  localparam int unsigned BD = 4;
  localparam int unsigned TS = 16;

  logic          clk_i = 1'b0;
  logic          resetn_i;
  logic          tx_ch_req_o, tx_ch_gnt_i, tx_ch_valid_i, tx_ch_ready_o;
  logic [AW-1:0] tx_ch_addr_o;
  logic [1:0]    tx_ch_datasize_o;
  logic [DW-1:0] tx_ch_data_i;
  logic          cmd_start_i, cmd_done_o;
  logic [AW-1:0] cfg_start_addr_i;
  logic [1:0]    cfg_datasize_i, cfg_mode_i;
  logic [TS-1:0] cfg_len0_i, cfg_len1_i, cfg_len2_i;
  logic [DW-1:0] stream_data_o;
  logic [1:0]    stream_datasize_o;
  logic          stream_valid_o, stream_sof_o, stream_eof_o, stream_ready_i;

  always #5 clk_i = ~clk_i;

  udma_filter_tx_datain #(
    .DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW), .BUFFER_DEPTH(BD), .TRANS_SIZE(TS)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .tx_ch_req_o(tx_ch_req_o), .tx_ch_addr_o(tx_ch_addr_o), .tx_ch_datasize_o(tx_ch_datasize_o),
    .tx_ch_gnt_i(tx_ch_gnt_i), .tx_ch_valid_i(tx_ch_valid_i), .tx_ch_data_i(tx_ch_data_i),
    .tx_ch_ready_o(tx_ch_ready_o), .cmd_start_i(cmd_start_i), .cmd_done_o(cmd_done_o),
    .cfg_start_addr_i(cfg_start_addr_i), .cfg_datasize_i(cfg_datasize_i), .cfg_mode_i(cfg_mode_i),
    .cfg_len0_i(cfg_len0_i), .cfg_len1_i(cfg_len1_i), .cfg_len2_i(cfg_len2_i),
    .stream_data_o(stream_data_o), .stream_datasize_o(stream_datasize_o),
    .stream_valid_o(stream_valid_o), .stream_sof_o(stream_sof_o), .stream_eof_o(stream_eof_o),
    .stream_ready_i(stream_ready_i)
  );

  typedef struct { logic [DW-1:0] data; logic sof; logic eof; logic [1:0] ds; } beat_t;
  typedef struct { logic [AW-1:0] addr; int due; } pend_t;

  logic [AW-1:0] exp_addr[$];
  beat_t         exp_beat[$];
  pend_t         pend[$];
  beat_t         eb;
  int n_vec = 0, n_err = 0;
  int cyc = 0, g_cnt = 0, m_out = 0, m_fifo = 0;
  int gnt_prob = 100, rdy_prob = 100, lat_max = 1;
  bit done_seen = 0;
  bit mg, mv, p_req = 0, p_gnt = 0, p_hold = 0;
  logic [AW-1:0] p_addr;
  logic [63:0]   p_stream, cur_stream;
  logic [31:0]   salt = 32'h1234_5678;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: element i of a command maps to (w,l) by traversal order; address = start + w*incr + l*len2.
  task automatic load_cmd(input int mode, input int sa, input int ds, input int l0, input int l1, input int l2);
    int incr, n0, n1, w, l;
    beat_t b;
    logic [AW-1:0] a;
    incr = (ds == 3) ? 0 : (1 << ds);
    n0 = l0 + 1;
    n1 = (mode == 1 || mode == 2) ? l1 + 1 : 1;
    for (int i = 0; i < n0 * n1; i++) begin
      if (mode == 2)      begin w = i / n1; l = i % n1; end
      else if (mode == 1) begin l = i / n0; w = i % n0; end
      else                begin w = i;      l = 0;      end
      a = AW'(sa + w * incr + l * l2);
      exp_addr.push_back(a);
      b.data = mem_word(a); b.sof = (i == 0); b.eof = (i == n0 * n1 - 1); b.ds = 2'(ds);
      exp_beat.push_back(b);
    end
  endtask

  // Caller must be at a rising edge; start is sampled on the following edge.
  task automatic start_cmd(input int mode, input int sa, input int ds, input int l0, input int l1, input int l2);
    #1;
    salt = $urandom;
    cfg_mode_i = 2'(mode); cfg_start_addr_i = AW'(sa); cfg_datasize_i = 2'(ds);
    cfg_len0_i = TS'(l0); cfg_len1_i = TS'(l1); cfg_len2_i = TS'(l2);
    load_cmd(mode, sa, ds, l0, l1, l2);
    cmd_start_i = 1'b1;
    @(posedge clk_i); #1;
    cmd_start_i = 1'b0;
  endtask

  task automatic flush();
    exp_addr.delete(); exp_beat.delete(); pend.delete();
    m_out = 0; m_fifo = 0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!done_seen && t < 3000) begin @(posedge clk_i); t++; end
    check({nm, "_done"}, 64'(done_seen), 64'(1));
    check({nm, "_drained"}, 64'(exp_addr.size() + exp_beat.size()), 64'(0));
    if (!done_seen) flush();
    done_seen = 0;
  endtask

  // L2 responder and stream sink: random grant/ready, in-order read data after a random latency.
  always @(posedge clk_i) begin
    cyc++;
    #1;
    tx_ch_valid_i  = 1'b0;
    tx_ch_gnt_i    = ($urandom_range(99) < gnt_prob);
    stream_ready_i = ($urandom_range(99) < rdy_prob);
    if (resetn_i && pend.size() > 0 && pend[0].due <= cyc) begin
      tx_ch_valid_i = 1'b1;
      tx_ch_data_i  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
  end

  // Monitor: samples at the falling edge what the next rising edge will commit.
  always @(negedge clk_i) begin
    if (resetn_i) begin
      mg = tx_ch_req_o && tx_ch_gnt_i;
      mv = tx_ch_valid_i && (m_out > 0);
      cur_stream = 64'({stream_valid_o, stream_sof_o, stream_eof_o, stream_data_o});
      if (tx_ch_req_o) check("credit", 64'((m_out + m_fifo) < BD), 64'(1));
      if (p_req && !p_gnt && tx_ch_req_o) check("addr_hold", 64'(tx_ch_addr_o), 64'(p_addr));
      if (p_hold) check("stream_hold", cur_stream, p_stream);
      if (mg) begin
        g_cnt++;
        if (exp_addr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_grant: got addr %0h, expected no request", tx_ch_addr_o);
        end else check("addr", 64'(tx_ch_addr_o), 64'(exp_addr.pop_front()));
        pend.push_back('{addr: tx_ch_addr_o, due: cyc + int'($urandom_range(lat_max, 1))});
      end
      if (stream_valid_o && stream_ready_i) begin
        if (exp_beat.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_beat: got data %0h, expected no beat", stream_data_o);
        end else begin
          eb = exp_beat.pop_front();
          check("beat", 64'({stream_data_o, stream_sof_o, stream_eof_o, stream_datasize_o, cmd_done_o}),
                64'({eb.data, eb.sof, eb.eof, eb.ds, eb.eof}));
        end
        if (cmd_done_o) done_seen = 1;
        m_fifo--;
      end else check("idle_done", 64'(cmd_done_o), 64'(0));
      if (mv) m_fifo++;
      m_out = m_out + int'(mg) - int'(mv);
      p_req  = tx_ch_req_o; p_gnt = tx_ch_gnt_i; p_addr = tx_ch_addr_o;
      p_hold = stream_valid_o && !stream_ready_i; p_stream = cur_stream;
    end else begin
      p_req = 0; p_hold = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn_i = 1'b0; cmd_start_i = 1'b0;
    cfg_start_addr_i = '0; cfg_datasize_i = '0; cfg_mode_i = '0;
    cfg_len0_i = '0; cfg_len1_i = '0; cfg_len2_i = '0;
    tx_ch_gnt_i = 1'b0; tx_ch_valid_i = 1'b0; tx_ch_data_i = '0; stream_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    check("rst_ctrl", 64'({tx_ch_req_o, cmd_done_o, stream_valid_o, stream_sof_o, stream_eof_o}), 64'(0));
    check("rst_addr", 64'(tx_ch_addr_o), 64'(0));
    check("rst_data", 64'(stream_data_o), 64'(0));
    check("ready_tied", 64'(tx_ch_ready_o), 64'(1));
    resetn_i = 1'b1;
    @(posedge clk_i);

    start_cmd(0, 'h100, 2, 3, 0, 0);         wait_done("linear");
    start_cmd(1, 'h0, 0, 1, 2, 'h10);        wait_done("row2d");
    start_cmd(2, 'h0, 0, 1, 2, 'h10);        wait_done("col2d");
    start_cmd(0, 'h0, 2, 0, 0, 0);           wait_done("single");
    start_cmd(0, 'h7FFC, 2, 1, 0, 0);        wait_done("wrap");
    start_cmd(3, 'h55, 3, 2, 1, 7);          wait_done("mode3");

    // Stream stalled: credits cap the number of grants at the buffer depth.
    rdy_prob = 0; g_cnt = 0;
    start_cmd(0, 'h40, 2, 7, 0, 0);
    repeat (20) @(posedge clk_i);
    #2;
    check("bp_grants_le_depth", 64'(g_cnt <= BD), 64'(1));
    check("bp_req_low", 64'(tx_ch_req_o), 64'(0));
    check("bp_fifo_full", 64'(m_fifo), 64'(BD));
    rdy_prob = 100;
    wait_done("backpressure");

    // Ignored restart while running, then reset mid-transfer.
    g_cnt = 0;
    start_cmd(0, 'h200, 2, 7, 0, 0);
    for (int t = 0; t < 100 && g_cnt < 2; t++) @(posedge clk_i);
    check("mid_progress", 64'(g_cnt >= 2), 64'(1));
    #1; cfg_start_addr_i = 'h3000; cfg_mode_i = 2'd1; cmd_start_i = 1'b1;
    @(posedge clk_i); #1; cmd_start_i = 1'b0;
    @(posedge clk_i); #2;
    resetn_i = 1'b0;
    #1;
    check("mid_rst_ctrl", 64'({tx_ch_req_o, cmd_done_o, stream_valid_o, stream_sof_o, stream_eof_o}), 64'(0));
    check("mid_rst_addr", 64'(tx_ch_addr_o), 64'(0));
    flush();
    repeat (3) @(posedge clk_i);
    check("mid_no_done", 64'(done_seen), 64'(0));
    #1; resetn_i = 1'b1;
    @(posedge clk_i);
    start_cmd(1, 'h123, 1, 2, 1, 'h40);      wait_done("after_reset");

    // Randomised commands, back to back, with random grant/ready/latency.
    for (int k = 0; k < 14; k++) begin
      gnt_prob = int'($urandom_range(100, 30));
      rdy_prob = int'($urandom_range(100, 30));
      lat_max  = int'($urandom_range(4, 1));
      start_cmd(int'($urandom_range(3)), int'($urandom_range(32767)), int'($urandom_range(3)),
                int'($urandom_range(4)), int'($urandom_range(3)), int'($urandom_range(65535)));
      wait_done("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
